// File: rtl/inst_memory_responder_if.sv
// Refill-side bus of the instruction memory responder: the icache block-read
// handshake plus the byte-wide program-image load port.
interface inst_memory_responder_if #(
    parameter int BLOCK_AW = 6,
    parameter int LINE_W   = 128
);
    localparam int LANE_AW = $clog2(LINE_W / 8);

    logic                          mem_read;
    logic [BLOCK_AW-1:0]           mem_address;
    logic [LINE_W-1:0]             mem_readdata;
    logic                          mem_busywait;

    logic                          load_en;
    logic [BLOCK_AW+LANE_AW-1:0]   load_addr;
    logic [7:0]                    load_data;
    logic                          load_ready;

    // Requester side: the icache and the image loader.
    modport master (
        output mem_read,
        output mem_address,
        output load_en,
        output load_addr,
        output load_data,
        input  mem_readdata,
        input  mem_busywait,
        input  load_ready
    );

    // Responder side: the memory itself.
    modport slave (
        input  mem_read,
        input  mem_address,
        input  load_en,
        input  load_addr,
        input  load_data,
        output mem_readdata,
        output mem_busywait,
        output load_ready
    );
endinterface

// File: rtl/inst_memory_responder.sv
// Instruction memory responder: returns a whole cache block a fixed number of
// cycles after a read is accepted, and accepts program-image bytes while idle.
module inst_memory_responder #(
    parameter int BLOCK_AW     = 6,
    parameter int LINE_W       = 128,
    parameter int READ_LATENCY = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    inst_memory_responder_if.slave  bus
);
    localparam int DEPTH   = 1 << BLOCK_AW;
    localparam int LANES   = LINE_W / 8;
    localparam int LANE_AW = $clog2(LANES);
    localparam int CNT_W   = 8;

    // With a single-cycle latency there is no BUSY phase at all.
    localparam bit SINGLE_CYCLE = (READ_LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(READ_LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_latency
        $error("inst_memory_responder: READ_LATENCY must be within 1..255");
    end

    logic [1:0]           state_q,    state_d;
    logic [CNT_W-1:0]     count_q,    count_d;
    logic [BLOCK_AW-1:0]  addr_q,     addr_d;
    logic [LINE_W-1:0]    readdata_q, readdata_d;

    logic [LINE_W-1:0]    mem_q [DEPTH];

    logic                 load_fire;
    logic [BLOCK_AW-1:0]  load_block;
    logic [LANE_AW-1:0]   load_lane;
    logic [LINE_W-1:0]    load_line;
    logic [LINE_W-1:0]    accept_line;

    assign load_block = bus.load_addr[BLOCK_AW+LANE_AW-1:LANE_AW];
    assign load_lane  = bus.load_addr[LANE_AW-1:0];
    assign load_fire  = bus.load_en && (state_q == ST_IDLE);

    // Build the updated block for a byte load by splicing the new byte into its lane.
    always_comb begin
        load_line = mem_q[load_block];
        load_line[{load_lane, 3'b000} +: 8] = bus.load_data;
    end

    // Block seen by a read accepted this edge; forwards a same-edge load so the
    // zero-wait-state variant agrees with the multi-cycle one.
    always_comb begin
        accept_line = mem_q[bus.mem_address];
        if (load_fire && (load_block == bus.mem_address)) begin
            accept_line = load_line;
        end
    end

    // Read sequencer: accept in IDLE, count down in BUSY, present data for one DONE cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        readdata_d = readdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_read) begin
                    addr_d = bus.mem_address;
                    if (SINGLE_CYCLE) begin
                        readdata_d = accept_line;
                        state_d    = ST_DONE;
                    end else begin
                        count_d = CNT_START;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (count_q == '0) begin
                    readdata_d = mem_q[addr_q];
                    state_d    = ST_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers; reset abandons any read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            readdata_q <= readdata_d;
        end
    end

    // Program image storage; deliberately survives reset so a loaded image persists.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            mem_q[load_block] <= load_line;
        end
    end

    assign bus.mem_busywait = ((state_q == ST_IDLE) && bus.mem_read) || (state_q == ST_BUSY);
    assign bus.load_ready   = (state_q == ST_IDLE);
    assign bus.mem_readdata = readdata_q;

endmodule

// File: tb/tb_inst_memory_responder.sv
// Scoreboard bench for inst_memory_responder: a 4-cycle and a 1-cycle instance
// share the load port; each read pushes its expected block and a per-instance
// monitor pops and compares whenever that instance presents DONE.
module tb_inst_memory_responder;
    localparam logic [127:0] BLK5    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] BLK5_AA = 128'h0F0E0D0C_0B0A0908_07060504_030201AA;
    localparam logic [127:0] BLK9    = 128'h9F9E9D9C_9B9A9998_97969594_93929190;

    logic        clock;
    logic        reset;
    logic        rd0;
    logic        rd1;
    logic [5:0]  addr;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [7:0]  load_data;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [127:0] q0 [$];
    logic [127:0] q1 [$];

    inst_memory_responder_if #(.BLOCK_AW(6), .LINE_W(128)) bus0 ();
    inst_memory_responder_if #(.BLOCK_AW(6), .LINE_W(128)) bus1 ();

    assign bus0.mem_read    = rd0;
    assign bus0.mem_address = addr;
    assign bus0.load_en     = load_en;
    assign bus0.load_addr   = load_addr;
    assign bus0.load_data   = load_data;

    assign bus1.mem_read    = rd1;
    assign bus1.mem_address = addr;
    assign bus1.load_en     = load_en;
    assign bus1.load_addr   = load_addr;
    assign bus1.load_data   = load_data;

    inst_memory_responder #(.BLOCK_AW(6), .LINE_W(128), .READ_LATENCY(4)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    inst_memory_responder #(.BLOCK_AW(6), .LINE_W(128), .READ_LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic get_bw(input int sel);
        return (sel == 0) ? bus0.mem_busywait : bus1.mem_busywait;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_block(input logic [5:0] blk, input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = {blk, 4'(i)};
            load_data = base + 8'(i);
            tick();
        end
        load_en = 1'b0;
    endtask

    // Issue one read, push its expected block, count busywait cycles up to DONE.
    // The address switches to late_addr and any pending load is dropped one cycle
    // after acceptance; with hold set, mem_read stays high past DONE.
    task automatic apply_stimulus(input string name, input int sel, input logic [5:0] a,
                                  input logic [5:0] late_addr, input logic [127:0] exp,
                                  input int exp_busy, input bit hold);
        int  busy;
        bit  done;
        busy = 0;
        done = 1'b0;
        if (sel == 0) begin
            rd0 = 1'b1;
            q0.push_back(exp);
        end else begin
            rd1 = 1'b1;
            q1.push_back(exp);
        end
        addr = a;
        #1;
        check_output({name, "_bw_rise"}, 128'(get_bw(sel)), 128'd1);
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clock);
            if (i == 1) begin
                addr    = late_addr;
                load_en = 1'b0;
            end
            if (get_bw(sel)) busy++;
            else done = 1'b1;
        end
        if (!done) begin
            check_cnt++;
            $display("[TB] FAIL %s_timeout: got no DONE expected DONE within 64 cycles", name);
        end
        check_output({name, "_busy_cycles"}, 128'(busy), 128'(exp_busy));
        tick();
        if (!hold) begin
            if (sel == 0) rd0 = 1'b0;
            else rd1 = 1'b0;
        end
    endtask

    // Monitor for the 4-cycle instance: DONE is busywait low while not ready for loads.
    always @(negedge clock) begin
        if (reset && !bus0.mem_busywait && !bus0.load_ready) begin
            if (q0.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL dut0_unexpected_done: got DONE data %h expected none",
                         bus0.mem_readdata);
            end else begin
                check_output("dut0_readdata", bus0.mem_readdata, q0.pop_front());
            end
        end
    end

    // Monitor for the 1-cycle instance.
    always @(negedge clock) begin
        if (reset && !bus1.mem_busywait && !bus1.load_ready) begin
            if (q1.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL dut1_unexpected_done: got DONE data %h expected none",
                         bus1.mem_readdata);
            end else begin
                check_output("dut1_readdata", bus1.mem_readdata, q1.pop_front());
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset     = 1'b0;
        rd0       = 1'b0;
        rd1       = 1'b0;
        addr      = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        #3;
        check_output("rst_busywait",   128'(bus0.mem_busywait), 128'd0);
        check_output("rst_readdata",   bus0.mem_readdata,       128'd0);
        check_output("rst_load_ready", 128'(bus0.load_ready),   128'd1);
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] loading blocks 5 and 9");
        load_block(6'd5, 8'h00);
        load_block(6'd9, 8'h90);

        apply_stimulus("t2_read5", 0, 6'd5, 6'd5, BLK5, 5, 1'b0);
        repeat (3) tick();
        check_output("t2_readdata_held", bus0.mem_readdata, BLK5);
        apply_stimulus("t6_rl1_read5", 1, 6'd5, 6'd5, BLK5, 1, 1'b0);
        tick();

        apply_stimulus("t3_addr_switch", 0, 6'd5, 6'd9, BLK5, 5, 1'b0);
        tick();

        apply_stimulus("t4_hold_first", 0, 6'd5, 6'd9, BLK5, 5, 1'b1);
        apply_stimulus("t4_hold_second", 0, 6'd9, 6'd9, BLK9, 5, 1'b0);
        tick();

        $display("[TB] reset during BUSY");
        rd0  = 1'b1;
        addr = 6'd5;
        tick();
        tick();
        reset = 1'b0;
        rd0   = 1'b0;
        #1;
        check_output("t1_busywait",   128'(bus0.mem_busywait), 128'd0);
        check_output("t1_readdata",   bus0.mem_readdata,       128'd0);
        check_output("t1_load_ready", 128'(bus0.load_ready),   128'd1);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        apply_stimulus("t5_reread5", 0, 6'd5, 6'd5, BLK5, 5, 1'b0);
        tick();

        $display("[TB] load during BUSY is dropped");
        rd0  = 1'b1;
        addr = 6'd5;
        q0.push_back(BLK5);
        tick();
        tick();
        load_en   = 1'b1;
        load_addr = {6'd5, 4'd0};
        load_data = 8'hAA;
        check_output("t6_busy_load_ready", 128'(bus0.load_ready), 128'd0);
        tick();
        load_en = 1'b0;
        for (int i = 0; i < 64 && bus0.mem_busywait; i++) @(negedge clock);
        tick();
        rd0 = 1'b0;
        tick();

        load_en   = 1'b1;
        load_addr = {6'd5, 4'd0};
        load_data = 8'hAA;
        apply_stimulus("t6_load_with_read", 0, 6'd5, 6'd5, BLK5_AA, 5, 1'b0);

        repeat (4) tick();
        check_output("q0_drained", 128'(q0.size()), 128'd0);
        check_output("q1_drained", 128'(q1.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
